// File: rtl/register_file.sv
// register_file: general-purpose register bank R0..R(DEPTH-1) for the datapath.
//
// One write port and two independent registered read ports (A, B). A read
// issued in the same cycle as a write to the same register returns the value
// being written, so the newest data always wins.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset, clears entries and read outputs
//   ce       - write enable, loads in into entry[waddr]
//   waddr    - write address (writes to waddr >= DEPTH are dropped)
//   in       - write data
//   re_a     - read request, port A
//   raddr_a  - read address, port A
//   out_a    - registered read data, port A (holds when idle)
//   valid_a  - high for the one cycle after a port A request
//   re_b     - read request, port B
//   raddr_b  - read address, port B
//   out_b    - registered read data, port B (holds when idle)
//   valid_b  - high for the one cycle after a port B request
module register_file #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] in,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] out_a,
  output logic             valid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_b_q;
  logic             valid_a_q, valid_b_q;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  // Read selection. Only addresses that match an implemented entry can select
  // anything, so an out-of-range address falls through to zero. The bypass
  // term shares the same match, which keeps it limited to in-range addresses.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (raddr_a == AW'(i)) begin
        rdata_a = (ce && (waddr == AW'(i))) ? in : mem_q[i];
      end
      if (raddr_b == AW'(i)) begin
        rdata_b = (ce && (waddr == AW'(i))) ? in : mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      out_a_q   <= '0;
      out_b_q   <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      // Decoded write: an address with no matching entry writes nothing.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ce && (waddr == AW'(i))) begin
          mem_q[i] <= in;
        end
      end
      valid_a_q <= re_a;
      valid_b_q <= re_b;
      if (re_a) begin
        out_a_q <= rdata_a;
      end
      if (re_b) begin
        out_b_q <= rdata_b;
      end
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;

endmodule
